// File: rtl/uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_frame_ctrl
//  Description : Frame controller between a UART RX/TX pair and a
//                combinational ALU. Collects [SYNC] A B OP from received
//                bytes, presents operands/opcode to the ALU, then sends the
//                ALU result (or ERR_BYTE for an illegal opcode) through a
//                start/done TX handshake. Supports an optional sync byte, an
//                inter-byte timeout, opcode checking and RX drop flagging.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk         in   1      clock, rising edge
//    i_reset_n     in   1      asynchronous active-low reset
//    i_rx_done     in   1      1-cycle pulse, i_rx_data valid
//    i_rx_data     in   DBIT   received byte
//    i_alu_result  in   DBIT   ALU result for o_data_a/o_data_b/o_operation
//    i_tx_done     in   1      1-cycle pulse, TX finished current byte
//    o_data_a      out  DBIT   operand A (registered)
//    o_data_b      out  DBIT   operand B (registered)
//    o_operation   out  NB_OP  opcode (registered)
//    o_tx_start    out  1      1-cycle pulse, start sending o_tx_data
//    o_tx_data     out  DBIT   byte to send, stable until i_tx_done
//    o_busy        out  1      high while executing or transmitting
//    o_frame_err   out  1      1-cycle pulse, timeout or illegal opcode
//    o_rx_drop     out  1      1-cycle pulse, byte received while busy
// ============================================================================
module uart_alu_frame_ctrl #(
    parameter int              DBIT        = 8,
    parameter int              NB_OP       = 6,
    parameter int              SYNC_EN     = 1,
    parameter logic [DBIT-1:0] SYNC_BYTE   = DBIT'(8'hA5),
    parameter logic [DBIT-1:0] ERR_BYTE    = DBIT'(8'hEE),
    parameter int              TIMEOUT_CYC = 100000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_rx_done,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_operation,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic             o_rx_drop
);

    localparam logic [2:0] c_S_SYNC  = 3'd0;
    localparam logic [2:0] c_S_A     = 3'd1;
    localparam logic [2:0] c_S_B     = 3'd2;
    localparam logic [2:0] c_S_OP    = 3'd3;
    localparam logic [2:0] c_S_EXEC  = 3'd4;
    localparam logic [2:0] c_S_TX    = 3'd5;
    localparam logic [2:0] c_S_START = (SYNC_EN != 0) ? c_S_SYNC : c_S_A;

    localparam int              c_TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYC - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [c_TW-1:0]  r_timer;
    logic             r_tx_first;
    logic [DBIT-1:0]  r_data_a;
    logic [DBIT-1:0]  r_data_b;
    logic [NB_OP-1:0] r_operation;
    logic [DBIT-1:0]  r_tx_data;
    logic             r_frame_err;
    logic             r_rx_drop;

    logic w_op_illegal;
    logic w_timer_run;
    logic w_timeout;
    logic w_busy;

    // Opcode bits above NB_OP must be zero; with a full-width opcode
    // there is nothing to check.
    generate
        if (NB_OP < DBIT) begin : g_opchk
            assign w_op_illegal = |i_rx_data[DBIT-1:NB_OP];
        end else begin : g_opchk_off
            assign w_op_illegal = 1'b0;
        end
    endgenerate

    // Without a sync stage, S_A is the idle state and must wait forever.
    assign w_timer_run = (r_state == c_S_B) || (r_state == c_S_OP) ||
                         ((SYNC_EN != 0) && (r_state == c_S_A));
    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout   = w_timer_run && !i_rx_done && (r_timer == c_TO_LAST);
    assign w_busy      = (r_state == c_S_EXEC) || (r_state == c_S_TX);

    // ---------------------------------------------------------------- state
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= c_S_START;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_SYNC: begin
                if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
                    w_next = c_S_A;
                end
            end
            c_S_A: begin
                if (i_rx_done) begin
                    w_next = c_S_B;
                end else if (w_timeout) begin
                    w_next = c_S_START;
                end
            end
            c_S_B: begin
                if (i_rx_done) begin
                    w_next = c_S_OP;
                end else if (w_timeout) begin
                    w_next = c_S_START;
                end
            end
            c_S_OP: begin
                if (i_rx_done) begin
                    w_next = w_op_illegal ? c_S_TX : c_S_EXEC;
                end else if (w_timeout) begin
                    w_next = c_S_START;
                end
            end
            c_S_EXEC: begin
                w_next = c_S_TX;
            end
            c_S_TX: begin
                // A done pulse coincident with the start pulse belongs to
                // nothing we sent, so only later pulses complete the TX.
                if (i_tx_done && !r_tx_first) begin
                    w_next = c_S_START;
                end
            end
            default: begin
                w_next = c_S_START;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        o_busy     = 1'b0;
        o_tx_start = 1'b0;
        if (w_busy) begin
            o_busy = 1'b1;
        end
        if ((r_state == c_S_TX) && r_tx_first) begin
            o_tx_start = 1'b1;
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_timer     <= '0;
            r_tx_first  <= 1'b0;
            r_data_a    <= '0;
            r_data_b    <= '0;
            r_operation <= '0;
            r_tx_data   <= '0;
            r_frame_err <= 1'b0;
            r_rx_drop   <= 1'b0;
        end else begin
            r_rx_drop   <= i_rx_done && w_busy;
            r_frame_err <= w_timeout ||
                           ((r_state == c_S_OP) && i_rx_done && w_op_illegal);
            r_tx_first  <= (w_next == c_S_TX) && (r_state != c_S_TX);

            if (!w_timer_run || i_rx_done || w_timeout) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                c_S_A: begin
                    if (i_rx_done) begin
                        r_data_a <= i_rx_data;
                    end
                end
                c_S_B: begin
                    if (i_rx_done) begin
                        r_data_b <= i_rx_data;
                    end
                end
                c_S_OP: begin
                    if (i_rx_done) begin
                        r_operation <= i_rx_data[NB_OP-1:0];
                        if (w_op_illegal) begin
                            r_tx_data <= ERR_BYTE;
                        end
                    end
                end
                c_S_EXEC: begin
                    // Operands have been stable for a full cycle here.
                    r_tx_data <= i_alu_result;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_data_a    = r_data_a;
    assign o_data_b    = r_data_b;
    assign o_operation = r_operation;
    assign o_tx_data   = r_tx_data;
    assign o_frame_err = r_frame_err;
    assign o_rx_drop   = r_rx_drop;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_alu_frame_ctrl
//  Description : Self-checking bench for uart_alu_frame_ctrl. Directed
//                frame table, hand sequences for timeout/drop/reset corner
//                cases, and random frames against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_frame_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       tx_done;
    logic [7:0] alu;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] operation;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_err;
    logic       rx_drop;

    always #5 clk = ~clk;

    uart_alu_frame_ctrl #(
        .DBIT(8), .NB_OP(6), .SYNC_EN(1),
        .SYNC_BYTE(8'hA5), .ERR_BYTE(8'hEE), .TIMEOUT_CYC(TO)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rx_done(rx_done), .i_rx_data(rx_data),
        .i_alu_result(alu), .i_tx_done(tx_done),
        .o_data_a(data_a), .o_data_b(data_b), .o_operation(operation),
        .o_tx_start(tx_start), .o_tx_data(tx_data), .o_busy(busy),
        .o_frame_err(frame_err), .o_rx_drop(rx_drop)
    );

    // Environment ALU: small opcode set, zero for anything else.
    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu = alu_f(data_a, data_b, operation);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op;
        logic [7:0] exp;
        bit         illegal;
    } vec_t;

    vec_t       vt[11];
    logic [7:0] legal_ops[7];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_start = 0;
    int         n_ferr  = 0;
    int         n_drop  = 0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];
    bit         auto_tx = 1'b0;
    int         tx_wait = 0;
    int         tx_delay = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: outputs are observed 1ns after the rising edge, pulses on
    // the inputs are released, and the optional TX responder is serviced.
    task automatic tick();
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        if (tx_start) begin
            n_start++;
            tx_q.push_back(tx_data);
            if (auto_tx) tx_wait = tx_delay;
        end else if (auto_tx && tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) tx_done = 1'b1;
        end
        if (frame_err) n_ferr++;
        if (rx_drop)   n_drop++;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [63:0] all_outs();
        return {30'd0, data_a, data_b, operation, tx_start, tx_data, busy, frame_err, rx_drop};
    endfunction

    // Full frame with exact latency and handshake checks.
    task automatic do_frame_vec(input vec_t v);
        send(8'hA5);
        send(v.a);
        send(v.b);
        send(v.op);
        if (v.illegal) begin
            check("ill_start_1clk", {63'd0, tx_start}, 1);
            check("ill_frame_err", {63'd0, frame_err}, 1);
        end else begin
            check("exec_no_start", {62'd0, busy, tx_start}, 2'b10);
            check("exec_no_err", {63'd0, frame_err}, 0);
            tick();
            check("start_latency", {63'd0, tx_start}, 1);
        end
        check("tx_data", {56'd0, tx_data}, {56'd0, v.exp});
        check("operands", {42'd0, data_a, data_b, operation},
              {42'd0, v.a, v.b, v.op[5:0]});
        tx_done = 1'b1;   // coincident with the start pulse
        tick();
        check("same_cycle_done_ignored", {62'd0, busy, tx_start}, 2'b10);
        tx_done = 1'b1;
        tick();
        check("tx_complete", {63'd0, busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         base_ferr;
        bit         early;
        logic [7:0] b;
        logic [7:0] a_r;
        logic [7:0] b_r;
        logic [7:0] op_r;
        logic [7:0] m_a;
        logic [7:0] m_b;
        logic [5:0] m_op;
        int         exp_ferr;
        int         exp_drop;
        bit         ill;

        vt[0]  = '{8'h12, 8'h34, 8'h20, 8'h46, 1'b0};
        vt[1]  = '{8'h01, 8'h02, 8'h20, 8'h03, 1'b0};
        vt[2]  = '{8'h12, 8'h34, 8'hC0, 8'hEE, 1'b1};
        vt[3]  = '{8'hF0, 8'h0F, 8'h24, 8'h00, 1'b0};
        vt[4]  = '{8'hFF, 8'h01, 8'h20, 8'h00, 1'b0};
        vt[5]  = '{8'h05, 8'h07, 8'h22, 8'hFE, 1'b0};
        vt[6]  = '{8'hAA, 8'h55, 8'h26, 8'hFF, 1'b0};
        vt[7]  = '{8'h3C, 8'h0F, 8'h25, 8'h3F, 1'b0};
        vt[8]  = '{8'h12, 8'h34, 8'h27, 8'hC9, 1'b0};
        vt[9]  = '{8'h9A, 8'hBC, 8'h40, 8'hEE, 1'b1};
        vt[10] = '{8'h77, 8'h88, 8'h3F, 8'h00, 1'b0};
        legal_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h3F};

        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        tx_done = 1'b0;
        #3;
        check("reset_outputs", all_outs(), 0);
        #10;
        rst_n = 1'b1;
        tick();
        check("post_reset_idle", all_outs(), 0);

        // Directed frame table; junk before the sync byte is ignored.
        for (int i = 0; i < 11; i++) begin
            if (i == 1) begin
                send(8'h00);
                send(8'h7F);
            end
            do_frame_vec(vt[i]);
        end

        // Timeout inside a frame: exactly TO idle clocks after the last byte.
        base = n_start;
        send(8'hA5);
        send(8'h12);
        early = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (frame_err) early = 1'b1;
        end
        check("timeout_not_early", {63'd0, early}, 0);
        tick();
        check("timeout_err_pulse", {62'd0, frame_err, busy}, 2'b10);
        tick();
        check("timeout_err_single", {63'd0, frame_err}, 0);
        check("timeout_no_tx", n_start, base);
        check("timeout_keeps_a", {56'd0, data_a}, 64'h12);
        do_frame_vec(vt[0]);

        // A byte on the expiry cycle is accepted.
        base_ferr = n_ferr;
        send(8'hA5);
        idle(TO - 1);
        send(8'h55);
        idle(TO - 1);
        send(8'h66);
        idle(TO - 1);
        send(8'h20);
        tick();
        check("expiry_byte_start", {63'd0, tx_start}, 1);
        check("expiry_byte_data", {56'd0, tx_data}, 64'hBB);
        check("expiry_byte_no_err", n_ferr, base_ferr);
        tick();
        tx_done = 1'b1;
        tick();
        check("expiry_tx_done", {63'd0, busy}, 0);

        // Byte received during TX is dropped and TX still completes.
        base = n_start;
        send(8'hA5);
        send(8'h11);
        send(8'h22);
        send(8'h20);
        tick();
        tick();
        send(8'hA5);
        check("drop_pulse", {62'd0, rx_drop, busy}, 2'b11);
        tx_done = 1'b1;
        tick();
        check("drop_tx_done", {62'd0, busy, rx_drop}, 0);
        check("drop_one_start", n_start, base + 1);
        do_frame_vec(vt[2]);
        // Stray tx_done while idle is ignored.
        tx_done = 1'b1;
        tick();
        check("stray_tx_done", {63'd0, busy}, 0);
        do_frame_vec(vt[5]);

        // Asynchronous reset in S_B and in S_TX.
        send(8'hA5);
        send(8'h12);
        rst_n = 1'b0;
        #2;
        check("async_reset_in_b", all_outs(), 0);
        #10;
        rst_n = 1'b1;
        base = n_start;
        idle(5);
        check("no_start_after_reset_b", n_start, base);
        send(8'hA5);
        send(8'h33);
        send(8'h44);
        send(8'h20);
        tick();
        check("pre_reset_tx_start", {63'd0, tx_start}, 1);
        base = n_start;
        rst_n = 1'b0;
        #2;
        check("async_reset_in_tx", all_outs(), 0);
        #10;
        rst_n = 1'b1;
        tx_done = 1'b1;
        tick();
        idle(10);
        check("no_start_after_reset_tx", n_start, base);
        do_frame_vec(vt[0]);

        // Random frames checked against a frame-level model.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        m_a = 8'h00; m_b = 8'h00; m_op = 6'h00;
        n_ferr = 0; n_drop = 0; exp_ferr = 0; exp_drop = 0;
        tx_q.delete();
        exp_q.delete();
        auto_tx = 1'b1;
        for (int f = 0; f < 40; f++) begin
            tx_delay = $urandom_range(1, 4);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                do b = 8'($urandom); while (b == 8'hA5);
                send(b);
                idle($urandom_range(0, 3));
            end
            send(8'hA5);
            idle($urandom_range(0, TO - 3));
            if ($urandom_range(0, 9) < 2) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                    b = 8'($urandom);
                    send(b);
                    if (j == 0) m_a = b; else m_b = b;
                    idle($urandom_range(0, TO - 3));
                end
                idle(TO + 2);
                exp_ferr++;
            end else begin
                a_r = 8'($urandom);
                b_r = 8'($urandom);
                ill = ($urandom_range(0, 3) == 0);
                if (ill) begin
                    op_r = 8'($urandom);
                    if (op_r[7:6] == 2'b00) op_r[7:6] = 2'b01;
                end else begin
                    op_r = legal_ops[$urandom_range(0, 6)];
                end
                send(a_r);
                idle($urandom_range(0, TO - 3));
                send(b_r);
                idle($urandom_range(0, TO - 3));
                send(op_r);
                if ($urandom_range(0, 2) == 0) begin
                    send(8'($urandom));
                    exp_drop++;
                end
                m_a = a_r;
                m_b = b_r;
                m_op = op_r[5:0];
                if (ill) begin
                    exp_q.push_back(8'hEE);
                    exp_ferr++;
                end else begin
                    exp_q.push_back(alu_f(a_r, b_r, op_r[5:0]));
                end
                for (int w = 0; w < 60 && (busy || tx_q.size() < exp_q.size()); w++) tick();
                check("rand_idle", {63'd0, busy}, 0);
            end
            tick();
            check("rand_tx_count", tx_q.size(), exp_q.size());
            while (tx_q.size() > 0 && exp_q.size() > 0) begin
                check("rand_tx_data", {56'd0, tx_q.pop_front()}, {56'd0, exp_q.pop_front()});
            end
            tx_q.delete();
            exp_q.delete();
            check("rand_frame_err", n_ferr, exp_ferr);
            check("rand_rx_drop", n_drop, exp_drop);
            check("rand_operands", {42'd0, data_a, data_b, operation}, {42'd0, m_a, m_b, m_op});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
